// File: rtl/round_key_sequencer.sv
// round_key_sequencer: buffers an expanded AES key schedule and streams round keys.
// Build option RKS_ZEROIZE_EN: wipe the key store when a sequence completes.
module round_key_sequencer #(
  parameter int NR = 10,
  parameter int KW = 128*(NR+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [0:KW-1] w_in,
  input  logic          decrypt,
  input  logic          rk_ready,
  output logic          rk_valid,
  output logic [0:127]  rk_data,
  output logic [3:0]    rk_round,
  output logic          rk_last,
  output logic          busy
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  localparam logic [3:0] NRC = 4'(NR);

  state_t        state;
  logic [0:KW-1] store;
  logic [3:0]    cnt;
  logic          dir;
  logic          at_end;
  logic          xfer;

  assign at_end   = dir ? (cnt == 4'd0) : (cnt == NRC);
  assign rk_valid = (state == STREAM);
  assign busy     = (state == STREAM);
  assign rk_last  = (state == STREAM) && at_end;
  assign rk_round = cnt;
  assign xfer     = (state == STREAM) && rk_ready;

  // Select the round key addressed by the counter out of the store.
  always_comb begin
    rk_data = '0;
    for (int r = 0; r <= NR; r++) begin
      if (cnt == 4'(r)) rk_data = store[128*r +: 128];
    end
  end

  // Sequencer state: load restarts, each accepted key steps the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      store <= '0;
      cnt   <= '0;
      dir   <= 1'b0;
    end else if (load) begin
      state <= STREAM;
      store <= w_in;
      dir   <= decrypt;
      cnt   <= decrypt ? NRC : 4'd0;
    end else if (xfer) begin
      if (at_end) begin
        state <= IDLE;
`ifdef RKS_ZEROIZE_EN
        store <= '0;
`else
        store <= store;
`endif
      end else if (dir) begin
        cnt <= cnt - 4'd1;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_round_key_sequencer.sv
// tb_round_key_sequencer: scoreboard bench for round_key_sequencer.
// Expected keys are queued at load time and popped on each transfer.
module tb_round_key_sequencer;

  localparam int NR = 10;
  localparam int KW = 128*(NR+1);

  typedef struct {
    logic [3:0]   r;
    logic [127:0] d;
    logic         l;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          load;
  logic [0:KW-1] w_in;
  logic          decrypt;
  logic          rk_ready;
  logic          rk_valid;
  logic [0:127]  rk_data;
  logic [3:0]    rk_round;
  logic          rk_last;
  logic          busy;

  round_key_sequencer #(.NR(NR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .w_in     (w_in),
    .decrypt  (decrypt),
    .rk_ready (rk_ready),
    .rk_valid (rk_valid),
    .rk_data  (rk_data),
    .rk_round (rk_round),
    .rk_last  (rk_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  exp_t q[$];
  logic         hold_pend;
  logic [3:0]   hold_r;
  logic [127:0] hold_d;
  logic [127:0] ka [0:10];
  logic [0:KW-1] sa;
  logic [0:KW-1] sb;
  logic [127:0] idle_exp;
  int bp [0:5] = '{1, 0, 0, 1, 0, 1};

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_seq(input logic [0:KW-1] s, input logic dec);
    exp_t e;
    for (int i = 0; i <= NR; i++) begin
      e.r = dec ? 4'(NR - i) : 4'(i);
      e.d = s[128*int'(e.r) +: 128];
      e.l = (i == NR);
      q.push_back(e);
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    if (hold_pend) begin
      chk("hold_round", 128'(rk_round), 128'(hold_r));
      chk("hold_data", rk_data, hold_d);
    end
    if (rk_valid && rk_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_key", 128'(rk_round), 128'hffff);
      end else begin
        e = q.pop_front();
        chk("rk_round", 128'(rk_round), 128'(e.r));
        chk("rk_data", rk_data, e.d);
        chk("rk_last", 128'(rk_last), 128'(e.l));
      end
    end
    chk("busy_eq_valid", 128'(busy), 128'(rk_valid));
    hold_pend = rk_valid && !rk_ready;
    hold_r = rk_round;
    hold_d = rk_data;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [0:KW-1] s, input logic dec);
    w_in = s;
    decrypt = dec;
    load = 1'b1;
    step();
    q.delete();
    push_seq(s, dec);
    load = 1'b0;
  endtask

  task automatic run(input bit pat);
    int n = 0;
    while (q.size() > 0 && n < 60) begin
      rk_ready = pat ? (bp[n % 6] != 0) : 1'b1;
      if (!pat) chk("valid_cont", 128'(rk_valid), 128'd1);
      step();
      n++;
    end
    chk("drained", 128'(q.size()), 128'd0);
    rk_ready = 1'b1;
  endtask

  task automatic run_to(input logic [3:0] r);
    int n = 0;
    while (!(rk_valid && rk_round == r) && n < 20) begin
      step();
      n++;
    end
    chk("reach_round", 128'(rk_round), 128'(r));
  endtask

  task automatic chk_idle(input string tag, input logic [127:0] d);
    chk({tag, "_valid"}, 128'(rk_valid), 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_last"}, 128'(rk_last), 128'd0);
    chk({tag, "_data"}, rk_data, d);
  endtask

  initial begin
    ka[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ka[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    ka[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    ka[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    ka[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    ka[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    ka[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    ka[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    ka[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    ka[9]  = 128'hac7766f319fadc2128d12941575c006e;
    ka[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int r = 0; r <= NR; r++) begin
      sa[128*r +: 128] = ka[r];
      sb[128*r +: 128] = {$urandom, $urandom, $urandom, 24'(r), 8'h5a};
    end
    hold_pend = 1'b0;
    hold_r = '0;
    hold_d = '0;
    rst_n = 1'b0;
    load = 1'b0;
    w_in = '0;
    decrypt = 1'b0;
    rk_ready = 1'b1;
    #12;
    chk_idle("reset", 128'd0);
    chk("reset_round", 128'(rk_round), 128'd0);
    rst_n = 1'b1;
    step();
    step();
    chk_idle("post_reset", 128'd0);

    // encrypt, then idle readback
    do_load(sa, 1'b0);
    run(1'b0);
`ifdef RKS_ZEROIZE_EN
    idle_exp = 128'd0;
`else
    idle_exp = ka[10];
`endif
    chk_idle("enc_done", idle_exp);

    // decrypt
    do_load(sa, 1'b1);
    run(1'b0);
`ifdef RKS_ZEROIZE_EN
    idle_exp = 128'd0;
`else
    idle_exp = ka[0];
`endif
    chk_idle("dec_done", idle_exp);

    // backpressure
    do_load(sa, 1'b0);
    run(1'b1);
    chk_idle("bp_done", (idle_exp == 0) ? 128'd0 : ka[10]);

    // abort at round 4, then load on the last transfer
    do_load(sa, 1'b0);
    run_to(4'd4);
    do_load(sb, 1'b0);
    chk("abort_round", 128'(rk_round), 128'd0);
    chk("abort_data", rk_data, sb[0 +: 128]);
    run_to(4'(NR));
    chk("last_flag", 128'(rk_last), 128'd1);
    do_load(sa, 1'b1);
    chk("relaunch_valid", 128'(rk_valid), 128'd1);
    chk("relaunch_round", 128'(rk_round), 128'(NR));
    run(1'b0);

    // asynchronous reset mid-stream
    do_load(sa, 1'b0);
    run_to(4'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst", 128'd0);
    chk("async_rst_round", 128'(rk_round), 128'd0);
    q.delete();
    hold_pend = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk_idle("rst_wait", 128'd0);
    do_load(sa, 1'b0);
    run(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
